// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared types for the UART RX framing path: FSM states, error codes and
// the default sync marker.
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ERR_FRAMING  = 3'd0,
    ERR_LENGTH   = 3'd1,
    ERR_CHECKSUM = 3'd2,
    ERR_TIMEOUT  = 3'd3,
    ERR_OVERRUN  = 3'd4
  } err_code_t;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: DEPTH x 8 register array, one synchronous write port and
// one combinational read port. Contents are not reset.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] ridx,
  output logic [7:0]    rdata
);

  // Only the low bits that can address DEPTH entries are used for indexing.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

  // Next-state of the array: copy, then overlay the written entry.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[widx[IW-1:0]] = wdata;
  end

  // Array storage.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Combinational read.
  always_comb begin
    rdata = mem_q[ridx[IW-1:0]];
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer for the uart_rx byte stream: hunts for SYNC_BYTE, captures
// LEN / payload / CHK, and releases the payload on a valid/ready stream only
// once the checksum passes. Errors pulse frame_err with err_code.
// Optional inter-byte timeout: define UART_RX_FRAME_CTRL_TIMEOUT_EN.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         MAX_LEN      = 16,
  parameter int         LEN_W        = $clog2(MAX_LEN + 1),
  parameter int         TIMEOUT_CLKS = 104_160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_get,
  input  logic       rx_error,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code,
  output logic       busy
);

  state_t           state_q, state_d;
  logic             rx_get_q;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] rd_q, rd_d;
  logic [7:0]       acc_q, acc_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_err_q, frame_err_d;
  logic [2:0]       err_code_q, err_code_d;

  logic             byte_stb;
  logic             buf_we;
  logic [7:0]       buf_rdata;
  logic [LEN_W-1:0] len_last;
  logic [7:0]       chk_sum;
  logic             hs;
  logic             tmo_hit;

  // rx_get is a level; only its rising edge marks a new byte.
  assign byte_stb = rx_get & ~rx_get_q;
  assign len_last = len_q - LEN_W'(1);
  assign chk_sum  = acc_q + rx_data;
  assign hs       = m_valid & m_ready;

`ifdef UART_RX_FRAME_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  logic [TW-1:0] tmo_q, tmo_d;

  // Inter-byte timer: runs only while a frame is being collected.
  always_comb begin
    if (byte_stb || state_q == HUNT || state_q == DRAIN) tmo_d = '0;
    else                                                 tmo_d = tmo_q + TW'(1);
  end

  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign tmo_hit = !byte_stb && (state_q == LEN || state_q == PAYLOAD || state_q == CHK)
                   && (tmo_q == TW'(TIMEOUT_CLKS - 1));

  // Timer register.
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (LEN_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .widx  (idx_q),
    .wdata (rx_data),
    .ridx  (rd_q),
    .rdata (buf_rdata)
  );

  // State and datapath registers; rx_get_q resets high so a level already
  // present at reset is not mistaken for a fresh byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      rx_get_q    <= 1'b1;
      len_q       <= '0;
      idx_q       <= '0;
      rd_q        <= '0;
      acc_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      rx_get_q    <= rx_get;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_q        <= rd_d;
      acc_q       <= acc_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Next-state, checksum accumulation, buffer writes and error classification.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    rd_d        = rd_q;
    acc_d       = acc_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = ERR_FRAMING;
    buf_we      = 1'b0;
    case (state_q)
      HUNT: begin
        // Bad bytes and noise are silently skipped while hunting.
        if (byte_stb && !rx_error && rx_data == SYNC_BYTE) state_d = LEN;
      end
      LEN: begin
        if (byte_stb) begin
          if (rx_error) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_FRAMING;
            state_d     = HUNT;
          end else if (rx_data == 8'h00 || rx_data > 8'(MAX_LEN)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LENGTH;
            state_d     = HUNT;
          end else begin
            len_d   = rx_data[LEN_W-1:0];
            acc_d   = rx_data;
            idx_d   = '0;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (byte_stb) begin
          if (rx_error) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_FRAMING;
            state_d     = HUNT;
          end else begin
            buf_we = 1'b1;
            acc_d  = acc_q + rx_data;
            idx_d  = idx_q + LEN_W'(1);
            if (idx_q == len_last) state_d = CHK;
          end
        end
      end
      CHK: begin
        if (byte_stb) begin
          if (rx_error) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_FRAMING;
            state_d     = HUNT;
          end else if (chk_sum == 8'h00) begin
            frame_ok_d = 1'b1;
            rd_d       = '0;
            state_d    = DRAIN;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHECKSUM;
            state_d     = HUNT;
          end
        end
      end
      DRAIN: begin
        if (hs) begin
          if (rd_q == len_last) state_d = HUNT;
          else                  rd_d    = rd_q + LEN_W'(1);
        end
        // A byte arriving before the payload is drained is lost; the
        // current frame keeps draining.
        if (byte_stb) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
      end
      default: state_d = HUNT;
    endcase
    if (tmo_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = HUNT;
    end
  end

  // Outputs decoded from registered state; m_data is zero outside DRAIN.
  always_comb begin
    m_valid   = (state_q == DRAIN);
    m_data    = m_valid ? buf_rdata : 8'h00;
    m_last    = m_valid && (rd_q == len_last);
    busy      = (state_q != HUNT);
    frame_ok  = frame_ok_q;
    frame_err = frame_err_q;
    err_code  = err_code_q;
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a scoreboard of expected
// payload bytes, error codes and frame_ok pulses.
module tb_uart_rx_frame_ctrl;

  localparam int TMO = 300;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_get;
  logic       rx_error;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       frame_ok;
  logic       frame_err;
  logic [2:0] err_code;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_d[$];   // {last, data}
  logic [2:0] exp_e[$];
  int         ok_pending = 0;
  logic [7:0] pl[$];

  uart_rx_frame_ctrl #(.TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_get(rx_get), .rx_error(rx_error),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        check("data_expected", exp_d.size() > 0, 1);
        if (exp_d.size() > 0) check("m_last_data", {m_last, m_data}, exp_d.pop_front());
      end
      if (frame_err) begin
        check("err_expected", exp_e.size() > 0, 1);
        if (exp_e.size() > 0) check("err_code", err_code, exp_e.pop_front());
      end
      if (frame_ok) begin
        check("ok_expected", ok_pending > 0, 1);
        if (ok_pending > 0) ok_pending--;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic e);
    @(posedge clk); #1;
    rx_data = b; rx_error = e; rx_get = 1'b1;
    repeat (3) @(posedge clk);
    #1 rx_get = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Sends SYNC, LEN, pl[] and a checksum; a bad frame gets CHK off by one.
  task automatic send_frame(input bit good);
    logic [7:0] s;
    logic [7:0] len;
    len = 8'(pl.size());
    s = len;
    foreach (pl[i]) s = s + pl[i];
    if (good) begin
      foreach (pl[i]) exp_d.push_back({(i == pl.size() - 1), pl[i]});
      ok_pending++;
    end else begin
      exp_e.push_back(3'd2);
    end
    send_byte(8'hA5, 1'b0);
    send_byte(len, 1'b0);
    foreach (pl[i]) send_byte(pl[i], 1'b0);
    send_byte(good ? 8'(8'h00 - s) : 8'(8'h00 - s - 8'h01), 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || m_valid) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    check(tag, n < 1000, 1);
  endtask

  initial begin
    logic [7:0] held;
    int n;
    rst = 1'b1; rx_get = 1'b1; rx_data = 8'hA5; rx_error = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {m_valid, m_last, frame_ok, frame_err, err_code, m_data, busy}, '0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stale_rx_get_busy", busy, 0);
    @(posedge clk); #1 rx_get = 1'b0;
    repeat (2) @(posedge clk);

    // Good frame, check the frame_ok / first-valid latency on the way.
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(1'b1);
    wait_idle("good_drain");

    // Bad checksum, then recovery.
    send_frame(1'b0);
    wait_idle("badchk_idle");
    pl = '{8'h44, 8'hA5, 8'h01};   // sync value inside payload is data
    send_frame(1'b1);
    wait_idle("after_bad_drain");

    // Length rejects.
    exp_e.push_back(3'd1);
    send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0);
    wait_idle("len0_idle");
    exp_e.push_back(3'd1);
    send_byte(8'hA5, 1'b0); send_byte(8'h11, 1'b0);
    wait_idle("len17_idle");

    // Max length and min length.
    pl.delete();
    for (int i = 0; i < 16; i++) pl.push_back(8'(8'hF0 + i));
    send_frame(1'b1);
    wait_idle("max_drain");
    pl = '{8'h7F};
    send_frame(1'b1);
    wait_idle("len1_drain");

    // Noise and an errored byte while hunting are ignored.
    send_byte(8'h7E, 1'b0); send_byte(8'h5A, 1'b0); send_byte(8'hA5, 1'b1);
    @(negedge clk);
    check("noise_busy", busy, 0);

    // Framing error on the second payload byte.
    exp_e.push_back(3'd0);
    send_byte(8'hA5, 1'b0); send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b1);
    wait_idle("framing_idle");

    // Backpressure: outputs stable for 50 cycles.
    @(posedge clk); #1 m_ready = 1'b0;
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(1'b1);
    n = 0;
    while (!m_valid && n < 100) begin @(posedge clk); n++; end
    check("bp_valid_seen", m_valid, 1);
    @(negedge clk);
    held = m_data;
    check("bp_first", held, 8'h11);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("bp_stable", {m_valid, m_last, m_data}, {1'b1, 1'b0, held});
    end

    // Overrun while still draining.
    exp_e.push_back(3'd4);
    send_byte(8'h55, 1'b0);
    @(negedge clk);
    check("overrun_busy", busy, 1);
    @(posedge clk); #1 m_ready = 1'b1;
    wait_idle("overrun_drain");

    // Timeout behaviour.
    send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h11, 1'b0);
`ifdef UART_RX_FRAME_CTRL_TIMEOUT_EN
    exp_e.push_back(3'd3);
    repeat (TMO + 20) @(posedge clk);
    @(negedge clk);
    check("timeout_busy", busy, 0);
`else
    repeat (TMO + 20) @(posedge clk);
    @(negedge clk);
    check("no_timeout_busy", busy, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("end_busy", busy, 0);
    check("sb_data_left", exp_d.size(), 0);
    check("sb_err_left", exp_e.size(), 0);
    check("sb_ok_left", ok_pending, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Sequences the byte stream produced by uart_rx into length-prefixed, checksummed frames.
- Hunts for a sync byte, then captures length, payload and checksum into an internal buffer.
- Releases the payload over a valid/ready stream only after the checksum passes (store-and-forward).
- Sits between uart_rx and the command decoder; all framing, timeout and error classification for the RX path lives here.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, maximum payload bytes per frame (1..255).
- LEN_W, $clog2(MAX_LEN+1), width of length/index counters.
- TIMEOUT_CLKS, 104_160, inter-byte timeout in clk cycles (20 bit times at 50 MHz / 9600 baud).

Ports:
- clk, in, 1, main clock.
- rst, in, 1, synchronous active-high reset.
- rx_data, in, 8, byte from uart_rx.
- rx_get, in, 1, uart_rx byte indicator; a level that stays high until the next start bit.
- rx_error, in, 1, uart_rx stop-bit error; valid alongside rx_get.
- m_data, out, 8, payload byte.
- m_valid, out, 1, m_data valid.
- m_ready, in, 1, downstream accepts byte.
- m_last, out, 1, marks the final payload byte.
- frame_ok, out, 1, one-cycle pulse when a frame passes its checksum.
- frame_err, out, 1, one-cycle pulse on any frame error.
- err_code, out, 3, error cause; valid with frame_err.
- busy, out, 1, high in any state other than HUNT.

Behaviour:
- **Reset** (synchronous, active-high): state=HUNT; m_valid=0, m_last=0, frame_ok=0, frame_err=0, err_code=0, m_data=0, busy=0. Buffer contents are don't-care. The internal rx_get delay register resets to 1, so a stale high level is not taken as a byte.
- **Byte strobe**: byte_stb = rx_get & ~rx_get_q, i.e. the 0->1 edge of rx_get. rx_data and rx_error are sampled on the byte_stb cycle. Exactly one byte is consumed per edge.
- **Checksum**: 8-bit accumulator, mod 256. A frame is valid when (LEN + sum(payload) + CHK) mod 256 == 8'h00.
- **err_code values**: 0 FRAMING, 1 LENGTH, 2 CHECKSUM, 3 TIMEOUT, 4 OVERRUN.

State machine:
- HUNT
  - byte_stb with rx_error=1: ignored, no error pulse.
  - byte_stb with byte==SYNC_BYTE: go to LEN.
  - byte_stb with any other byte: ignored.
- LEN, on byte_stb:
  - rx_error=1: FRAMING error.
  - byte==0 or byte>MAX_LEN: LENGTH error.
  - Otherwise: store len, acc=byte, idx=0, go to PAYLOAD.
- PAYLOAD, on byte_stb:
  - rx_error=1: FRAMING error.
  - Otherwise: buf[idx]=byte, acc+=byte, idx++.
  - When idx reaches len-1 on this strobe, go to CHK.
- CHK, on byte_stb:
  - rx_error=1: FRAMING error.
  - (acc+byte)==0: frame_ok pulses the next cycle; go to DRAIN with rd=0.
  - Otherwise: CHECKSUM error.
- DRAIN
  - m_valid=1, m_data=buf[rd], m_last=(rd==len-1).
  - On m_valid&m_ready: rd++.
  - On a last-byte handshake: m_valid drops the next cycle; go to HUNT.
  - m_data and m_last are held stable while m_valid=1 and m_ready=0.
  - First m_valid appears the cycle after the checksum byte is accepted.
- Any error
  - frame_err=1 and err_code pulse for one cycle (registered); go to HUNT.
  - Buffer contents are discarded; m_valid never asserts for a failed frame.
- Overrun: byte_stb during DRAIN drops the byte and pulses frame_err with OVERRUN. DRAIN continues; no state change.
- Boundaries:
  - len==1: PAYLOAD lasts one byte.
  - len==MAX_LEN: idx uses the full range with no wrap.
  - A SYNC_BYTE value inside LEN/PAYLOAD/CHK is treated as data, with no resync.

Optional Feature:
- Macro: UART_RX_FRAME_CTRL_TIMEOUT_EN.
- Defined:
  - Timeout counter: cleared on every byte_stb and in HUNT/DRAIN, incremented in LEN/PAYLOAD/CHK.
  - Reaching TIMEOUT_CLKS-1 raises a TIMEOUT error and returns to HUNT.
  - If byte_stb and timeout coincide, the byte wins.
- Undefined: no counter logic; a partial frame waits indefinitely; code 3 is never produced.

Decomposition:
- Package uart_pkg holds:
  - state enum {HUNT, LEN, PAYLOAD, CHK, DRAIN}
  - err_code enum with the values above
  - SYNC_BYTE default constant
- One natural sub-module, uart_frame_buf: MAX_LEN x 8 register array with a write port (we, widx, wdata) and a combinational read port (ridx → rdata).
- The FSM, checksum and handshake stay in uart_rx_frame_ctrl.

Test Plan:
- **Good frame**: bytes A5 03 11 22 33 97 with m_ready=1 → frame_ok pulse; m_data 11,22,33 on consecutive handshakes; m_last only with 33; frame_err never asserts.
- **Bad checksum**: A5 03 11 22 33 96 → frame_err, err_code=2; m_valid stays 0; next valid frame accepted normally.
- **Length rejects**:
  - A5 00 → err_code=1.
  - A5 11 with MAX_LEN=16 → err_code=1.
  - A5 10 followed by 16 payload bytes and the correct CHK → accepted; m_last on the 16th byte.
- **Backpressure/overrun**:
  - Good frame with m_ready held 0 for 50 cycles → m_data/m_valid stable throughout.
  - A byte strobe during DRAIN → err_code=4; remaining bytes still drain intact.
- **Framing and glitch**: rx_error=1 on the second payload byte → err_code=0, return to HUNT. Preceding 7E 5A noise → ignored. rx_get held high across reset → no byte taken.
- **Timeout** (macro defined): A5 02 11 then silence for TIMEOUT_CLKS → err_code=3. Macro undefined → busy remains 1.
